// File: rtl/lp805x_fsctl.sv
// -----------------------------------------------------------------------------
// lp805x_fsctl
//
// Frequency-scaling request controller. Arbitrates between two requesters
// that want a new clock-division factor. It sequences lp805x_schedfs through
// a start/settle cycle and returns the resulting schedule index to the winner.
// This is the only driver of the scheduler's start/factor/enable inputs.
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   enable        global run enable; low freezes every register
//   req0/req1     level requests, held until the matching ack
//   factor0/1     requested factor, stable while the request is high
//   ack0/ack1     one-cycle completion pulse to the granted requester
//   err           valid with ack; 1 = request rejected (factor 0)
//   idx_out       valid with ack; schedule index for the granted factor
//   busy          high whenever the FSM is not idle
//   cur_index     last committed schedule index
//   sched_start   start pulse to the scheduler
//   sched_factor  factor presented to the scheduler (holds between issues)
//   sched_enable  mirror of enable
//   sched_index   index returned by the scheduler
// -----------------------------------------------------------------------------
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a request; arbitrates and latches the granted factor
// ISSUE | one cycle; pulses sched_start and loads the settle counter
// WAIT  | settle countdown; samples sched_index when the counter reaches 0
// ACK   | one cycle; pulses the granted ack and records the grant for RR
//
module lp805x_fsctl #(
    parameter int FWIDTH = 9,
    parameter int IWIDTH = 3,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              req0,
    input  logic [FWIDTH-1:0] factor0,
    output logic              ack0,
    input  logic              req1,
    input  logic [FWIDTH-1:0] factor1,
    output logic              ack1,
    output logic              err,
    output logic [IWIDTH-1:0] idx_out,
    output logic              busy,
    output logic [IWIDTH-1:0] cur_index,
    output logic              sched_start,
    output logic [FWIDTH-1:0] sched_factor,
    output logic              sched_enable,
    input  logic [IWIDTH-1:0] sched_index
);

    localparam int CWIDTH = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CWIDTH-1:0] CNT_LOAD = CWIDTH'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CWIDTH-1:0]   cnt_q;
    logic [FWIDTH-1:0]   lat_factor;
    logic [FWIDTH-1:0]   cur_factor;
    logic                gnt_q;
    logic                last_grant;
    logic                issue_q;
    logic                ack_q;

    logic                grant_valid;
    logic                grant_sel;
    logic [FWIDTH-1:0]   sel_factor;

    // Next-state and arbitration. On a tie the requester that was not granted
    // last wins; last_grant resets to 1 so requester 0 takes the first tie.
    always_comb begin
        state_d     = state_q;
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        sel_factor  = factor0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_valid = 1'b1;
                    grant_sel   = (req0 && req1) ? ~last_grant : req1;
                    sel_factor  = grant_sel ? factor1 : factor0;
                    // Zero is rejected and an unchanged factor is a no-op;
                    // neither restarts the scheduler.
                    if ((sel_factor == '0) || (sel_factor == cur_factor)) begin
                        state_d = ACK;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                end
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every register, state and counter included, holds while enable is low,
    // so a pending start/ack pulse reappears once enable returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lat_factor   <= '0;
            cur_factor   <= '0;
            gnt_q        <= 1'b0;
            last_grant   <= 1'b1;
            issue_q      <= 1'b0;
            ack_q        <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            idx_out      <= '0;
            cur_index    <= '0;
            sched_factor <= '0;
        end else if (enable) begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            issue_q <= (state_d == ISSUE);
            ack_q   <= (state_d == ACK);
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        gnt_q      <= grant_sel;
                        lat_factor <= sel_factor;
                        err        <= (sel_factor == '0);
                        idx_out    <= cur_index;
                        if (state_d == ISSUE) begin
                            sched_factor <= sel_factor;
                        end
                    end
                end
                ISSUE: cnt_q <= CNT_LOAD;
                WAIT: begin
                    if (cnt_q == '0) begin
                        idx_out    <= sched_index;
                        cur_index  <= sched_index;
                        cur_factor <= lat_factor;
                    end else begin
                        cnt_q <= cnt_q - CWIDTH'(1);
                    end
                end
                ACK: last_grant <= gnt_q;
                default: ;
            endcase
        end
    end

    assign sched_enable = enable;
    assign sched_start  = enable & issue_q;
    assign ack0         = enable & ack_q & ~gnt_q;
    assign ack1         = enable & ack_q & gnt_q;

endmodule

// File: tb/tb_lp805x_fsctl.sv
`timescale 1ns/1ps
module tb_lp805x_fsctl;

    localparam int FWIDTH = 9;
    localparam int IWIDTH = 3;
    localparam int SETTLE = 4;
    localparam int LAT    = SETTLE + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              req0, req1;
    logic [FWIDTH-1:0] factor0, factor1;
    logic              ack0, ack1, err, busy;
    logic [IWIDTH-1:0] idx_out, cur_index, sched_index;
    logic              sched_start, sched_enable;
    logic [FWIDTH-1:0] sched_factor;

    lp805x_fsctl #(.FWIDTH(FWIDTH), .IWIDTH(IWIDTH), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .req0         (req0),
        .factor0      (factor0),
        .ack0         (ack0),
        .req1         (req1),
        .factor1      (factor1),
        .ack1         (ack1),
        .err          (err),
        .idx_out      (idx_out),
        .busy         (busy),
        .cur_index    (cur_index),
        .sched_start  (sched_start),
        .sched_factor (sched_factor),
        .sched_enable (sched_enable),
        .sched_index  (sched_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       gnt;
        logic       err;
        logic [2:0] idx;
        int         cyc;
    } ack_exp_t;

    typedef struct {
        int         cyc;
        logic [8:0] fac;
    } st_exp_t;

    typedef struct {
        logic       r;
        logic [8:0] f;
        logic       exp_err;
        logic [2:0] exp_idx;
        int         exp_lat;
        logic       exp_start;
    } vec_t;

    ack_exp_t sb_q[$];
    st_exp_t  st_q[$];
    ack_exp_t m_ack;
    st_exp_t  m_st;
    vec_t     tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scheduler model: index is a fixed function of the factor.
    function automatic logic [2:0] midx(input logic [8:0] f);
        return f[2:0] + 3'd5;
    endfunction

    task automatic push_ack(input logic g, input logic e, input logic [2:0] i, input int c);
        ack_exp_t x;
        x.gnt = g; x.err = e; x.idx = i; x.cyc = c;
        sb_q.push_back(x);
    endtask

    task automatic push_st(input int c, input logic [8:0] f);
        st_exp_t x;
        x.cyc = c; x.fac = f;
        st_q.push_back(x);
    endtask

    // Scheduler stand-in: presents its index from the cycle after the start
    // pulse, and an unrelated value once the transaction has been acked.
    initial begin : sched_model
        logic [8:0] f;
        sched_index = 3'd3;
        forever begin
            @(negedge clk);
            if (sched_start) begin
                f = sched_factor;
                @(posedge clk); #1;
                sched_index = midx(f);
            end else if (ack0 || ack1) begin
                @(posedge clk); #1;
                sched_index = 3'd3;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (ack0 || ack1) begin
            if (sb_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_ack: ack0=%0d ack1=%0d at cycle %0d, expected no ack", ack0, ack1, cyc);
            end else begin
                m_ack = sb_q.pop_front();
                chk("ack_cycle", cyc, m_ack.cyc);
                chk("ack_which", {ack1, ack0}, m_ack.gnt ? 32'd2 : 32'd1);
                chk("err", err, m_ack.err);
                chk("idx_out", idx_out, m_ack.idx);
                chk("cur_index", cur_index, m_ack.idx);
            end
        end
        if (sched_start) begin
            if (st_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_start: sched_start=1 at cycle %0d, expected 0", cyc);
            end else begin
                m_st = st_q.pop_front();
                chk("start_cycle", cyc, m_st.cyc);
                chk("sched_factor", sched_factor, m_st.fac);
            end
        end
        if (!enable) chk("gated_pulses", {ack0, ack1, sched_start}, 32'd0);
        chk("sched_enable", sched_enable, enable);
    end

    // Waits for the ack of requester r, counting busy cycles. Enable is driven
    // low for len cycles starting at transaction cycle s.
    task automatic wait_ack(input logic r, input int t0, input int s, input int len, output int nbusy);
        logic got;
        got   = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (r ? ack1 : ack0) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            enable = !(((cyc - t0) >= s) && ((cyc - t0) < s + len));
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL ack_timeout: ack%0d never seen, expected within 100 cycles", r);
        end
        enable = 1'b1;
    endtask

    task automatic drop(input logic r);
        @(posedge clk); #1;
        if (r) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic run_req(input logic r, input logic [8:0] f, input logic e, input logic [2:0] i,
                           input int lat, input logic st, input int s, input int len);
        int t0, nb;
        @(posedge clk); #1;
        if (r) begin req1 = 1'b1; factor1 = f; end
        else   begin req0 = 1'b1; factor0 = f; end
        t0 = cyc;
        push_ack(r, e, i, t0 + lat);
        if (st) push_st(t0 + 1, f);
        wait_ack(r, t0, s, len, nb);
        chk("busy_cycles", nb, lat);
        drop(r);
    endtask

    task automatic tie(input logic [8:0] f0, input logic [8:0] f1, input logic first);
        int t0, nb;
        logic [8:0] ff, fs;
        ff = first ? f1 : f0;
        fs = first ? f0 : f1;
        @(posedge clk); #1;
        req0 = 1'b1; factor0 = f0;
        req1 = 1'b1; factor1 = f1;
        t0 = cyc;
        push_st(t0 + 1, ff);
        push_ack(first, 1'b0, midx(ff), t0 + LAT);
        push_st(t0 + LAT + 2, fs);
        push_ack(~first, 1'b0, midx(fs), t0 + 2 * LAT + 1);
        wait_ack(first, t0, -1, 0, nb);
        drop(first);
        wait_ack(~first, t0, -1, 0, nb);
        drop(~first);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ack0"}, ack0, 0);
        chk({tag, "_ack1"}, ack1, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sched_start"}, sched_start, 0);
        chk({tag, "_idx_out"}, idx_out, 0);
        chk({tag, "_cur_index"}, cur_index, 0);
        chk({tag, "_sched_factor"}, sched_factor, 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1);
    end

    initial begin : main
        int t0;
        // {requester, factor, err, idx, ack latency, scheduler started}
        tbl[0] = '{1'b0, 9'd5,   1'b0, 3'd2, LAT, 1'b1};  // basic request
        tbl[1] = '{1'b1, 9'd0,   1'b1, 3'd2, 1,   1'b0};  // reject
        tbl[2] = '{1'b0, 9'd5,   1'b0, 3'd2, 1,   1'b0};  // no-op, same factor
        tbl[3] = '{1'b1, 9'd300, 1'b0, 3'd1, LAT, 1'b1};
        tbl[4] = '{1'b1, 9'd300, 1'b0, 3'd1, 1,   1'b0};
        tbl[5] = '{1'b0, 9'd0,   1'b1, 3'd1, 1,   1'b0};
        tbl[6] = '{1'b0, 9'd511, 1'b0, 3'd4, LAT, 1'b1};
        tbl[7] = '{1'b1, 9'd1,   1'b0, 3'd6, LAT, 1'b1};

        rst = 1'b1; enable = 1'b1;
        req0 = 1'b0; req1 = 1'b0; factor0 = '0; factor1 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        for (int i = 0; i < 8; i++) begin
            run_req(tbl[i].r, tbl[i].f, tbl[i].exp_err, tbl[i].exp_idx,
                    tbl[i].exp_lat, tbl[i].exp_start, -1, 0);
        end

        // Round-robin: last grant was requester 1, so requester 0 wins twice,
        // then after a lone requester-0 grant the tie goes to requester 1.
        tie(9'd8, 9'd15, 1'b0);
        tie(9'd8, 9'd15, 1'b0);
        run_req(1'b0, 9'd8, 1'b0, midx(9'd8), LAT, 1'b1, -1, 0);
        tie(9'd8, 9'd15, 1'b1);

        // Enable low for 3 WAIT cycles, then for 2 cycles while in ACK.
        run_req(1'b0, 9'd100, 1'b0, midx(9'd100), LAT + 3, 1'b1, 3, 3);
        run_req(1'b0, 9'd200, 1'b0, midx(9'd200), LAT + 2, 1'b1, 6, 2);

        // Reset in the second WAIT cycle: no ack, state and index cleared.
        @(posedge clk); #1;
        req0 = 1'b1; factor0 = 9'd77;
        t0 = cyc;
        push_st(t0 + 1, 9'd77);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        chk("busy_before_rst", busy, 1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        repeat (8) @(negedge clk);
        run_req(1'b0, 9'd501, 1'b0, midx(9'd501), LAT, 1'b1, -1, 0);

        repeat (3) @(negedge clk);
        chk("ack_queue_empty", sb_q.size(), 0);
        chk("start_queue_empty", st_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
